// File: rtl/oam_dma_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_controller_pkg
//  Description : Shared definitions for the OAM DMA controller: 2-bit state
//                encodings, default trigger/destination addresses and the
//                trigger-decode helper used by the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package oam_dma_controller_pkg;

    // Explicit 2-bit state encodings; the enum below is bound to these values.
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_halt  = 2'd1;
    localparam logic [1:0] c_st_read  = 2'd2;
    localparam logic [1:0] c_st_write = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_HALT  = c_st_halt,
        ST_READ  = c_st_read,
        ST_WRITE = c_st_write
    } dma_state_t;

    // CPU write address that starts a transfer.
    localparam logic [15:0] c_default_trigger_addr = 16'h4014;
    // Fixed destination of every DMA write (sprite data port).
    localparam logic [15:0] c_default_dest_addr    = 16'h2004;

    // A trigger is a CPU *write* to the trigger address; reads never start DMA.
    function automatic logic is_trigger_write(
        input logic [15:0] address,
        input logic        read_write,
        input logic [15:0] trigger_addr
    );
        return (read_write == 1'b0) && (address == trigger_addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_bus_mux.sv
`default_nettype none
// ============================================================================
//  Module      : dma_bus_mux
//  Description : Combinational memory-bus selector. In IDLE the CPU bus is
//                passed straight through; in every other state the
//                DMA-generated address/direction/data drive the memory.
//  Ports       : state             - controller state (selects the source)
//                cpu_*             - CPU bus request
//                dma_*             - DMA-generated bus request
//                mem_*             - bus presented to memory
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_bus_mux
    import oam_dma_controller_pkg::*;
(
    input  dma_state_t  state,
    input  logic [15:0] cpu_address,
    input  logic        cpu_read_write,
    input  logic [7:0]  cpu_data_write,
    input  logic [15:0] dma_address,
    input  logic        dma_read_write,
    input  logic [7:0]  dma_data_write,
    output logic [15:0] mem_address,
    output logic        mem_read_write,
    output logic [7:0]  mem_data_write
);

    always_comb begin
        mem_address    = cpu_address;
        mem_read_write = cpu_read_write;
        mem_data_write = cpu_data_write;
        if (state != ST_IDLE) begin
            mem_address    = dma_address;
            mem_read_write = dma_read_write;
            mem_data_write = dma_data_write;
        end
    end

endmodule
`default_nettype wire

// File: rtl/oam_dma_controller.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_controller
//  Description : OAM DMA engine. A CPU write to TRIGGER_ADDR latches a source
//                page, halts the CPU and copies 256 bytes from {page,00..FF}
//                to DEST_ADDR as alternating read/write cycles
//                (1 dummy HALT cycle + 512 = 513 cycles per transfer).
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                cpu_address/cpu_read_write/cpu_data_write - CPU bus request
//                data_read         - memory read data (shared with the CPU)
//                mem_address/mem_read_write/mem_data_write - bus to memory
//                cpu_halt          - CPU clock-enable-low while DMA is active
//                dma_busy          - high whenever the engine is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_controller
    import oam_dma_controller_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR = c_default_trigger_addr,
    parameter logic [15:0] DEST_ADDR    = c_default_dest_addr
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_address,
    input  logic        cpu_read_write,
    input  logic [7:0]  cpu_data_write,
    input  logic [7:0]  data_read,
    output logic [15:0] mem_address,
    output logic        mem_read_write,
    output logic [7:0]  mem_data_write,
    output logic        cpu_halt,
    output logic        dma_busy
);

    dma_state_t  r_state;
    dma_state_t  w_state_next;
    logic [7:0]  r_page;
    logic [7:0]  r_counter;
    logic [7:0]  r_buffer;

    logic        w_start;
    logic        w_capture;
    logic        w_advance;

    logic [15:0] w_dma_address;
    logic        w_dma_read_write;
    logic [7:0]  w_dma_data_write;

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_page    <= 8'h00;
            r_counter <= 8'h00;
            r_buffer  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_page    <= cpu_data_write;
                r_counter <= 8'h00;
            end
            if (w_capture) begin
                r_buffer <= data_read;
            end
            // 8-bit increment: wraps FF -> 00 as the transfer ends.
            if (w_advance) begin
                r_counter <= r_counter + 8'h01;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. cpu_* inputs are only looked at in IDLE, so a
    // trigger write during a transfer can never restart it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (is_trigger_write(cpu_address, cpu_read_write, TRIGGER_ADDR)) begin
                    w_state_next = ST_HALT;
                    w_start      = 1'b1;
                end
            end
            ST_HALT: begin
                w_state_next = ST_READ;
            end
            ST_READ: begin
                w_capture    = 1'b1;
                w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_advance = 1'b1;
                if (r_counter == 8'hFF) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_READ;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // DMA-side bus request. The HALT cycle is a dummy read of whatever
    // address the (now frozen) CPU is presenting.
    // ------------------------------------------------------------------
    always_comb begin
        w_dma_address    = cpu_address;
        w_dma_read_write = 1'b1;
        w_dma_data_write = r_buffer;
        case (r_state)
            ST_READ: begin
                w_dma_address    = {r_page, r_counter};
                w_dma_read_write = 1'b1;
            end
            ST_WRITE: begin
                w_dma_address    = DEST_ADDR;
                w_dma_read_write = 1'b0;
            end
            default: begin
                w_dma_address    = cpu_address;
                w_dma_read_write = 1'b1;
            end
        endcase
    end

    dma_bus_mux u_bus_mux (
        .state          (r_state),
        .cpu_address    (cpu_address),
        .cpu_read_write (cpu_read_write),
        .cpu_data_write (cpu_data_write),
        .dma_address    (w_dma_address),
        .dma_read_write (w_dma_read_write),
        .dma_data_write (w_dma_data_write),
        .mem_address    (mem_address),
        .mem_read_write (mem_read_write),
        .mem_data_write (mem_data_write)
    );

    assign dma_busy = (r_state != ST_IDLE);
    assign cpu_halt = (r_state != ST_IDLE);

endmodule
`default_nettype wire
